// File: rtl/intr_ctrl_prio.sv
// Prioritised interrupt controller: per-channel edge/level latching, enable mask,
// lowest-index-wins vector presented to the CPU and held until acknowledged.
module intr_ctrl_prio #(
    parameter int                NUM_CH     = 8,
    parameter logic [NUM_CH-1:0] EN_RESET   = {NUM_CH{1'b1}},
    parameter logic [NUM_CH-1:0] MODE_RESET = {NUM_CH{1'b1}},
    localparam int               VEC_W      = $clog2(NUM_CH)
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [NUM_CH-1:0] I_intr_rq,
    input  logic              I_intr_ack,
    input  logic              I_we,
    input  logic [1:0]        I_addr,
    input  logic [NUM_CH-1:0] I_wdata,
    output logic              O_intr,
    output logic [VEC_W-1:0]  O_intr_vector,
    output logic [NUM_CH-1:0] O_pending,
    output logic [NUM_CH-1:0] O_enable,
    output logic              O_dbg_state
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic                r_intr;
    logic [VEC_W-1:0]    r_vector;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_prev_rq;
    logic [NUM_CH-1:0]   r_enable;
    logic [NUM_CH-1:0]   r_mode;

    logic [NUM_CH-1:0]   w_hw_set;
    logic [NUM_CH-1:0]   w_set;
    logic [NUM_CH-1:0]   w_clr;
    logic [NUM_CH-1:0]   w_req;
    logic [VEC_W-1:0]    w_sel;
    logic                w_ack;

    // Handshake: O_intr/O_intr_vector stay stable from grant until I_intr_ack is
    // sampled high in WAIT; an ack seen in IDLE is a no-op.
    always_comb begin
        w_ack    = (r_state == ST_WAIT) && I_intr_ack;
        w_hw_set = (I_intr_rq & ~r_prev_rq & r_mode) | (I_intr_rq & ~r_mode);
        w_set    = w_hw_set | ((I_we && I_addr == 2'd3) ? I_wdata : '0);
        w_clr    = ((I_we && I_addr == 2'd2) ? I_wdata : '0)
                 | (w_ack ? (ONE_HOT0 << r_vector) : '0);
        w_req    = r_pending & r_enable;
        w_sel    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel = VEC_W'(i);
            end
        end
    end

    // Set is OR'd in after the clear so a coincident event is never lost.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_pending <= '0;
            r_prev_rq <= '0;
            r_enable  <= EN_RESET;
            r_mode    <= MODE_RESET;
        end else begin
            r_prev_rq <= I_intr_rq;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (I_we && I_addr == 2'd0) begin
                r_enable <= I_wdata;
            end
            if (I_we && I_addr == 2'd1) begin
                r_mode <= I_wdata;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state  <= ST_IDLE;
            r_intr   <= 1'b0;
            r_vector <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req != '0) begin
                        r_vector <= w_sel;
                        r_intr   <= 1'b1;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (I_intr_ack) begin
                        r_intr  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_intr        = r_intr;
    assign O_intr_vector = r_vector;
    assign O_pending     = r_pending;
    assign O_enable      = r_enable;
    assign O_dbg_state   = r_state;

endmodule

// File: tb/tb_intr_ctrl_prio.sv
// Directed bench for intr_ctrl_prio (NUM_CH=8): hand-computed expectations per edge.
module tb_intr_ctrl_prio;

    logic       clk;
    logic       rst_n;
    logic [7:0] rq;
    logic       ack;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       intr;
    logic [2:0] vec;
    logic [7:0] pend;
    logic [7:0] en;
    logic       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    intr_ctrl_prio #(.NUM_CH(8)) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_intr_rq     (rq),
        .I_intr_ack    (ack),
        .I_we          (we),
        .I_addr        (addr),
        .I_wdata       (wdata),
        .O_intr        (intr),
        .O_intr_vector (vec),
        .O_pending     (pend),
        .O_enable      (en),
        .O_dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; addr = 2'd0; wdata = 8'h00;
    endtask

    task automatic pulse_rq(input logic [7:0] m);
        rq = m;
        tick();
        rq = 8'h00;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rq = 8'h00; ack = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
        #12;
        check("rst_intr", intr, 0);
        check("rst_vec", vec, 0);
        check("rst_pend", pend, 8'h00);
        check("rst_en", en, 8'hFF);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // single edge pulse on ch5: pending at first edge, O_intr at second
        pulse_rq(8'h20);
        check("t1_pend", pend, 8'h20);
        check("t1_intr_early", intr, 0);
        tick();
        check("t1_intr", intr, 1);
        check("t1_vec", vec, 5);
        check("t1_state", dbg_state, 1);
        do_ack();
        check("t1_ack_intr", intr, 0);
        check("t1_ack_pend", pend, 8'h00);
        check("t1_vec_held", vec, 5);
        tick();
        check("t1_idle", intr, 0);

        // simultaneous ch6 + ch2: ch2 first, then ch6 after a one-cycle gap
        pulse_rq(8'h44);
        tick();
        check("t2_vec_a", vec, 2);
        check("t2_intr_a", intr, 1);
        do_ack();
        check("t2_gap", intr, 0);
        check("t2_pend", pend, 8'h40);
        tick();
        check("t2_intr_b", intr, 1);
        check("t2_vec_b", vec, 6);
        do_ack();
        check("t2_pend_end", pend, 8'h00);

        // masked channel stays pending and fires once enabled
        reg_write(2'd0, 8'hFB);
        check("t3_en", en, 8'hFB);
        pulse_rq(8'h04);
        tick();
        check("t3_masked_intr", intr, 0);
        check("t3_masked_pend", pend, 8'h04);
        reg_write(2'd0, 8'hFF);
        check("t3_after_wr", intr, 0);
        tick();
        check("t3_intr", intr, 1);
        check("t3_vec", vec, 2);
        do_ack();
        check("t3_pend_end", pend, 8'h00);

        // level mode on ch3, line held through the ack
        reg_write(2'd1, 8'hF7);
        rq = 8'h08;
        tick();
        check("t4_pend", pend, 8'h08);
        tick();
        check("t4_intr", intr, 1);
        check("t4_vec", vec, 3);
        do_ack();
        check("t4_gap", intr, 0);
        check("t4_reset_pend", pend, 8'h08);
        tick();
        check("t4_refire", intr, 1);
        check("t4_refire_vec", vec, 3);
        rq = 8'h00;
        tick();
        do_ack();
        check("t4_drop_pend", pend, 8'h00);
        check("t4_drop_intr", intr, 0);
        tick();
        check("t4_no_refire", intr, 0);
        reg_write(2'd1, 8'hFF);

        // software set, W1C during WAIT, no preemption by higher priority
        reg_write(2'd3, 8'h10);
        check("t5_sw_pend", pend, 8'h10);
        tick();
        check("t5_intr", intr, 1);
        check("t5_vec", vec, 4);
        reg_write(2'd2, 8'h10);
        check("t5_w1c_pend", pend, 8'h00);
        check("t5_w1c_intr", intr, 1);
        pulse_rq(8'h01);
        tick();
        check("t5_nopreempt_vec", vec, 4);
        check("t5_nopreempt_intr", intr, 1);
        check("t5_hi_pend", pend, 8'h01);
        do_ack();
        check("t5_ack_intr", intr, 0);
        check("t5_ack_pend", pend, 8'h01);
        tick();
        check("t5_ch0_vec", vec, 0);
        check("t5_ch0_intr", intr, 1);
        do_ack();

        // ack in IDLE is ignored
        reg_write(2'd0, 8'h7F);
        reg_write(2'd3, 8'h80);
        do_ack();
        check("t6_idle_ack_pend", pend, 8'h80);
        check("t6_idle_ack_intr", intr, 0);
        reg_write(2'd2, 8'h80);
        check("t6_w1c", pend, 8'h00);

        // asynchronous reset during WAIT (enable still 0x7F beforehand)
        pulse_rq(8'h02);
        tick();
        check("t7_intr", intr, 1);
        check("t7_vec", vec, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_intr", intr, 0);
        check("t7_async_pend", pend, 8'h00);
        check("t7_async_en", en, 8'hFF);
        check("t7_async_state", dbg_state, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t7_post_intr", intr, 0);
        check("t7_post_pend", pend, 8'h00);

        // edge mode: line already high at reset release counts as an edge
        rst_n = 1'b0;
        rq = 8'h80;
        tick();
        rst_n = 1'b1;
        tick();
        check("t8_pend", pend, 8'h80);
        tick();
        check("t8_intr", intr, 1);
        check("t8_vec", vec, 7);
        do_ack();
        check("t8_ack_pend", pend, 8'h00);
        tick();
        check("t8_no_refire", intr, 0);
        rq = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
